// File: rtl/serializer_pkg.sv
// Shared types and helpers for the bit serializer.
// Compile with SERIALIZER_PARITY_EN defined to append an even-parity bit to every frame.
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Number of serial bits per frame, including the optional parity bit.
  function automatic int frame_len(input int width);
`ifdef SERIALIZER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  // Counter width with headroom for the parity bit.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/frame_bit_counter.sv
// Bit position counter for one serial frame; saturates at FRAME_LEN-1 and flags it
// with terminal, which the top uses as the last-bit marker.
module frame_bit_counter
  import serializer_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] count_reg;

  assign terminal = (count_reg == LAST_IDX);

  // Clear wins over enable so a new frame always starts from bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !terminal) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: WIDTH-bit words in over valid/ready, MSB-first bits out.
// Optional even-parity bit after the LSB when SERIALIZER_PARITY_EN is defined.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int CNT_W     = cnt_width(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg;
  logic             transfer;
  logic             terminal;
  logic             fill_bit;

  // in_ready depends only on registered state, never on in_valid.
  assign ser_last  = (state_reg == SHIFT) && terminal;
  assign in_ready  = (state_reg == IDLE) || ser_last;
  assign transfer  = in_valid && in_ready;
  assign ser_valid = (state_reg == SHIFT);
  assign busy      = (state_reg == SHIFT);
  assign ser_out   = shift_reg[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (transfer) state_next = SHIFT;
      SHIFT: if (ser_last && !transfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef SERIALIZER_PARITY_EN
  // The parity bit enters at the LSB on the first shift and reaches the MSB
  // exactly when the counter hits WIDTH, keeping ser_out a pure register bit.
  logic         parity_reg;
  logic [WIDTH:0] parity_chain;

  assign parity_chain[0] = 1'b0;
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_parity
    assign parity_chain[gi+1] = parity_chain[gi] ^ in_data[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_reg <= 1'b0;
    end else if (transfer) begin
      parity_reg <= parity_chain[WIDTH];
    end else if (state_reg == SHIFT) begin
      parity_reg <= 1'b0;
    end
  end

  assign fill_bit = parity_reg;
`else
  assign fill_bit = 1'b0;
`endif

  // Zeros shift in behind the frame, so ser_out is already 0 on return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
    end else if (transfer) begin
      shift_reg <= in_data;
    end else if (state_reg == SHIFT) begin
      shift_reg <= {shift_reg[WIDTH-2:0], fill_bit};
    end
  end

  frame_bit_counter #(
    .FRAME_LEN(FRAME_LEN),
    .CNT_W    (CNT_W)
  ) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (transfer || ser_last),
    .enable  (state_reg == SHIFT),
    .terminal(terminal)
  );

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end that feeds a single bit per clock into the downstream D flip-flop / shift chain. Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB-first on a one-bit serial output, with a per-bit valid and a last-bit marker. Back-to-back words stream with zero idle cycles between frames.

## Interface
- WIDTH, 8, data word width; legal range 2..32
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream word available
- in_ready  output  1  block can accept a word this cycle
- in_data  input  WIDTH  word to serialize; sampled only on handshake
- ser_out  output  1  current serial bit
- ser_valid  output  1  ser_out carries a frame bit this cycle
- ser_last  output  1  current bit is the final bit of the frame
- busy  output  1  a frame is in progress (state SHIFT)

One clock, clk; reset rst_n is asynchronous and active-low.

## Operation
- States: IDLE, SHIFT. Reset enters IDLE.
- Handshake: transfer occurs on a rising edge where in_valid && in_ready. in_data is captured into the shift register and bit counter cleared to 0.
- in_ready = (state==IDLE) || (state==SHIFT && ser_last); combinational from state/counter only, never from in_valid.
- IDLE -> SHIFT on transfer. SHIFT -> SHIFT on transfer during the last bit (next frame starts immediately). SHIFT -> IDLE after the last bit when no transfer occurs.
- In SHIFT: ser_out = shift register MSB; each edge shifts left by one, filling 0 at LSB; counter increments.
- ser_last = 1 when counter == FRAME_LEN-1 in SHIFT; FRAME_LEN = WIDTH (or WIDTH+1, see Configuration).
- ser_valid = busy = (state==SHIFT).
- in_valid while in_ready=0: ignored, no capture; upstream holds data.
- Counter width $clog2(WIDTH+2); never wraps past FRAME_LEN-1.

## Timing
- Reset values: in_ready=1, ser_out=0, ser_valid=0, ser_last=0, busy=0; shift register and counter 0.
- rst_n low mid-frame: all outputs to reset values immediately (asynchronous), frame discarded, no partial bits after release.
- Latency: first bit (MSB) valid the cycle after the handshake edge.
- Frame occupies exactly FRAME_LEN consecutive ser_valid cycles; ser_last high in the final one only.
- Continuous in_valid: ser_valid stays high indefinitely, one ser_last every FRAME_LEN cycles.
- ser_out is registered; all outputs glitch-free except in_ready (combinational, depends on registered state only).

## Configuration
- Macro SERIALIZER_PARITY_EN.
- Defined: even parity of the captured word computed at handshake and appended after the LSB; FRAME_LEN = WIDTH+1; ser_last marks the parity bit.
- Undefined: no parity bit; FRAME_LEN = WIDTH; no parity logic synthesized.

## Structure
- Shared package serializer_pkg: state encodings (IDLE=0, SHIFT=1), WIDTH bounds, FRAME_LEN derivation helper.
- One sub-module: frame_bit_counter (clear, enable, terminal-count output = ser_last), same clk/rst_n.
- Top holds FSM, shift register, parity register.

## Test plan
- Reset: assert rst_n=0 with in_valid=1 -> in_ready=1, ser_valid=0, ser_out=0; no capture.
- Single word 8'hA5, WIDTH=8, no parity -> ser_out 1,0,1,0,0,1,0,1 on 8 cycles, ser_last on 8th, then IDLE.
- Back-to-back 8'hFF then 8'h00 held valid -> 16 contiguous ser_valid cycles, ser_last at cycles 8 and 16, in_ready high only at cycles 8 and 16.
- in_valid pulsed mid-frame (in_ready=0) with 8'h3C -> ignored; current frame bits unchanged.
- rst_n low at bit 4 of 8'hA5 -> outputs zero immediately; after release, next word 8'h81 emits 1,0,0,0,0,0,0,1 cleanly.
- With SERIALIZER_PARITY_EN, 8'h07 -> 8 data bits then parity bit 1, ser_last on 9th cycle; 8'h03 -> parity bit 0.
